// File: rtl/ysyx_201979054_icache_refill_ctrl_pkg.sv
// Shared types and sizing for the instruction-cache refill controller.
package ysyx_201979054_icache_refill_ctrl_pkg;

    localparam int DEF_BLOCK_WIDTH = 512;
    localparam int DEF_BEAT_WIDTH  = 64;
    localparam int DEF_ADDR_WIDTH  = 64;
    localparam int BEATS           = DEF_BLOCK_WIDTH / DEF_BEAT_WIDTH;
    localparam int LINE_OFF_W      = $clog2(DEF_BLOCK_WIDTH / 8);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FILL,
        S_WRITE
    } refill_state_t;

    function automatic int line_off_width(input int block_width);
        return $clog2(block_width / 8);
    endfunction

    function automatic int beat_idx_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/ysyx_201979054_icache_refill_ctrl_if.sv
// Read-address / read-data channel between the refill controller and memory.
interface ysyx_201979054_icache_refill_ctrl_if
    import ysyx_201979054_icache_refill_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BEAT_WIDTH = DEF_BEAT_WIDTH
);

    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  rvalid;
    logic                  rready;
    logic [BEAT_WIDTH-1:0] rdata;
    logic                  rlast;

    modport master (
        output arvalid, araddr, rready,
        input  arready, rvalid, rdata, rlast
    );

    modport slave (
        input  arvalid, araddr, rready,
        output arready, rvalid, rdata, rlast
    );

endinterface

// File: rtl/ysyx_201979054_icache_refill_ctrl_line_buffer.sv
// Refill line buffer: one beat written per accepted read beat, whole line read out.
module ysyx_201979054_line_buffer #(
    parameter int BLOCK_WIDTH = 512,
    parameter int BEAT_WIDTH  = 64,
    parameter int IDX_W       = 3
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   we,
    input  logic [IDX_W-1:0]       idx,
    input  logic [BEAT_WIDTH-1:0]  wdata,
    output logic [BLOCK_WIDTH-1:0] line
);

    always_ff @(posedge clk) begin
        if (arst) begin
            line <= '0;
        end else if (we) begin
            line[BEAT_WIDTH*idx +: BEAT_WIDTH] <= wdata;
        end
    end

endmodule

// File: rtl/ysyx_201979054_icache_refill_ctrl.sv
// I-cache miss handler: fetches one line over a burst read channel and writes it into the cache.
//   state   | meaning
//   S_IDLE  | serve hits, detect miss or fence.i
//   S_REQ   | present line address until memory accepts it
//   S_FILL  | collect BEATS read beats into the line buffer
//   S_WRITE | one-cycle cache write of the assembled line
module ysyx_201979054_icache_refill_ctrl
    import ysyx_201979054_icache_refill_ctrl_pkg::*;
#(
    parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH,
    parameter int BEAT_WIDTH  = DEF_BEAT_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   i_fetch_req,
    input  logic [ADDR_WIDTH-1:0]  i_instr_addr,
    input  logic                   i_hit,
    input  logic                   i_instr_addr_ma,
    input  logic                   i_fence_i,
    output logic                   o_stall,
    output logic                   o_cache_we,
    output logic                   o_invalidate,
    output logic [ADDR_WIDTH-1:0]  o_cache_addr,
    output logic [BLOCK_WIDTH-1:0] o_cache_line,
    ysyx_201979054_icache_refill_ctrl_if.master mem,
    output logic                   o_protocol_err,
    output logic [31:0]            o_miss_count
);

    localparam int NBEATS = BLOCK_WIDTH / BEAT_WIDTH;
    localparam int OFF_W  = line_off_width(BLOCK_WIDTH);
    localparam int CNT_W  = beat_idx_width(NBEATS);

    refill_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] line_addr_q;
    logic [CNT_W-1:0]      beat_q;
    logic                  fence_pend_q;
    logic                  inv_q;
    logic                  perr_q;
    logic [31:0]           miss_cnt_q;
    logic                  miss;
    logic                  beat_acc;
    logic                  last_beat;
    logic                  start_refill;

    assign miss         = i_fetch_req & ~i_hit & ~i_instr_addr_ma;
    assign start_refill = (state_q == S_IDLE) & miss & ~i_fence_i;
    assign beat_acc     = (state_q == S_FILL) & mem.rvalid;
    assign last_beat    = (beat_q == CNT_W'(NBEATS - 1));

    always_comb begin
        state_d     = state_q;
        o_stall     = 1'b0;
        mem.arvalid = 1'b0;
        mem.rready  = 1'b0;
        o_cache_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_stall = miss;
                if (start_refill) state_d = S_REQ;
            end
            S_REQ: begin
                o_stall     = 1'b1;
                mem.arvalid = 1'b1;
                if (mem.arready) state_d = S_FILL;
            end
            S_FILL: begin
                o_stall    = 1'b1;
                mem.rready = 1'b1;
                // rlast is only advisory; the beat count alone ends the burst
                if (beat_acc && last_beat) state_d = S_WRITE;
            end
            S_WRITE: begin
                o_stall    = 1'b1;
                o_cache_we = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q      <= S_IDLE;
            line_addr_q  <= '0;
            beat_q       <= '0;
            fence_pend_q <= 1'b0;
            inv_q        <= 1'b0;
            perr_q       <= 1'b0;
            miss_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_refill) begin
                line_addr_q <= {i_instr_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            end
            if (state_q == S_REQ && mem.arready) begin
                beat_q <= '0;
            end else if (beat_acc) begin
                beat_q <= beat_q + 1'b1;
            end
            perr_q <= beat_acc & (mem.rlast != last_beat);
            // a fence seen mid-refill is held and released right after the line lands
            inv_q <= (i_fence_i & ((state_q == S_IDLE) | (state_q == S_WRITE)))
                   | ((state_q == S_WRITE) & fence_pend_q);
            if (state_q == S_WRITE) begin
                fence_pend_q <= 1'b0;
            end else if (i_fence_i && state_q != S_IDLE) begin
                fence_pend_q <= 1'b1;
            end
            if (state_q == S_WRITE) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    ysyx_201979054_line_buffer #(
        .BLOCK_WIDTH (BLOCK_WIDTH),
        .BEAT_WIDTH  (BEAT_WIDTH),
        .IDX_W       (CNT_W)
    ) u_line_buffer (
        .clk   (clk),
        .arst  (arst),
        .we    (beat_acc),
        .idx   (beat_q),
        .wdata (mem.rdata),
        .line  (o_cache_line)
    );

    assign mem.araddr     = line_addr_q;
    assign o_cache_addr   = (state_q == S_WRITE) ? line_addr_q : i_instr_addr;
    assign o_invalidate   = inv_q;
    assign o_protocol_err = perr_q;
    assign o_miss_count   = miss_cnt_q;

endmodule

// File: tb/tb_ysyx_201979054_icache_refill_ctrl.sv
// Bench for the i-cache refill controller: directed scenarios plus random traffic against a transaction model.
module tb_ysyx_201979054_icache_refill_ctrl;
    import ysyx_201979054_icache_refill_ctrl_pkg::*;

    localparam int PH_IDLE  = 0;
    localparam int PH_ADDR  = 1;
    localparam int PH_DATA  = 2;
    localparam int PH_WRITE = 3;

    logic         clk;
    logic         arst;
    logic         fetch_req, hit, ma, fence;
    logic [63:0]  instr_addr;
    logic         stall, cache_we, inv, perr;
    logic [63:0]  cache_addr;
    logic [511:0] cache_line;
    logic [31:0]  miss_count;

    int errors = 0;
    int checks = 0;

    ysyx_201979054_icache_refill_ctrl_if #(.ADDR_WIDTH(64), .BEAT_WIDTH(64)) mem_if ();

    ysyx_201979054_icache_refill_ctrl #(
        .BLOCK_WIDTH(512), .BEAT_WIDTH(64), .ADDR_WIDTH(64)
    ) dut (
        .clk(clk), .arst(arst),
        .i_fetch_req(fetch_req), .i_instr_addr(instr_addr), .i_hit(hit),
        .i_instr_addr_ma(ma), .i_fence_i(fence),
        .o_stall(stall), .o_cache_we(cache_we), .o_invalidate(inv),
        .o_cache_addr(cache_addr), .o_cache_line(cache_line),
        .mem(mem_if), .o_protocol_err(perr), .o_miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_b(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_w(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_l(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_i(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    logic       rand_mode = 1'b0;
    int         ar_delay  = 0;
    logic       gap       = 1'b0;
    logic [7:0] rlast_mask = 8'h80;
    int         rb = 0;
    int         ar_cnt = 0;
    logic       gap_ph = 1'b0;

    initial begin
        logic acc_ar, acc_r, rst_s;
        mem_if.arready = 1'b0;
        mem_if.rvalid  = 1'b0;
        mem_if.rdata   = '0;
        mem_if.rlast   = 1'b0;
        forever begin
            @(negedge clk);
            acc_ar = mem_if.arvalid && mem_if.arready;
            acc_r  = mem_if.rvalid && mem_if.rready;
            rst_s  = arst;
            @(posedge clk);
            #1;
            if (rst_s || acc_ar) rb = 0;
            else if (acc_r) rb++;
            if (mem_if.arvalid) ar_cnt++;
            else ar_cnt = 0;
            gap_ph = ~gap_ph;
            if (rand_mode) begin
                mem_if.arready = ($urandom_range(0, 2) != 0);
                mem_if.rvalid  = ($urandom_range(0, 3) != 0);
                mem_if.rdata   = {$urandom, $urandom};
                mem_if.rlast   = ($urandom_range(0, 9) == 0) ? (rb != BEATS - 1) : (rb == BEATS - 1);
            end else begin
                mem_if.arready = mem_if.arvalid && (ar_cnt > ar_delay);
                mem_if.rvalid  = mem_if.rready && (gap ? gap_ph : 1'b1);
                mem_if.rdata   = 64'h1111_1111_1111_1111 * 64'(rb + 1);
                mem_if.rlast   = rlast_mask[rb % 8];
            end
        end
    end

    // ---------------- transaction model + per-cycle compare ----------------
    logic        m_valid = 1'b0;
    int          m_ph = PH_IDLE;
    int          m_k = 0;
    logic [63:0] m_line_addr = '0;
    logic [63:0] m_beats [BEATS];
    logic        m_pend = 1'b0, m_inv = 1'b0, m_perr = 1'b0;
    int unsigned m_count = 0;
    int obs_we = 0, obs_ar = 0, obs_perr = 0, obs_inv = 0;

    initial begin
        logic         m_miss, inv_nx, perr_nx;
        logic [511:0] exp_line;
        int           old_ph;
        forever begin
            @(negedge clk);
            if (cache_we === 1'b1) obs_we++;
            if (mem_if.arvalid === 1'b1) obs_ar++;
            if (perr === 1'b1) obs_perr++;
            if (inv === 1'b1) obs_inv++;
            m_miss = fetch_req & ~hit & ~ma;
            if (m_valid) begin
                chk_b("stall", stall, (m_ph == PH_IDLE) ? m_miss : 1'b1);
                chk_b("arvalid", mem_if.arvalid, m_ph == PH_ADDR);
                chk_b("rready", mem_if.rready, m_ph == PH_DATA);
                chk_b("cache_we", cache_we, m_ph == PH_WRITE);
                chk_b("invalidate", inv, m_inv);
                chk_b("protocol_err", perr, m_perr);
                chk_w("miss_count", 64'(miss_count), 64'(m_count));
                chk_w("cache_addr", cache_addr, (m_ph == PH_WRITE) ? m_line_addr : instr_addr);
                if (m_ph == PH_ADDR) chk_w("araddr", mem_if.araddr, m_line_addr);
                if (m_ph == PH_WRITE) begin
                    for (int i = 0; i < BEATS; i++) exp_line[i*64 +: 64] = m_beats[i];
                    chk_l("cache_line", cache_line, exp_line);
                end
            end
            if (arst) begin
                m_valid = 1'b1;
                m_ph = PH_IDLE; m_k = 0; m_pend = 1'b0; m_inv = 1'b0; m_perr = 1'b0; m_count = 0;
                for (int i = 0; i < BEATS; i++) m_beats[i] = '0;
            end else if (m_valid) begin
                inv_nx = 1'b0;
                perr_nx = 1'b0;
                old_ph = m_ph;
                if (m_ph == PH_IDLE) begin
                    if (fence) inv_nx = 1'b1;
                    else if (m_miss) begin
                        m_line_addr = instr_addr & ~((64'd1 << LINE_OFF_W) - 64'd1);
                        m_ph = PH_ADDR;
                    end
                end else if (m_ph == PH_ADDR) begin
                    if (mem_if.arready) begin m_ph = PH_DATA; m_k = 0; end
                end else if (m_ph == PH_DATA) begin
                    if (mem_if.rvalid) begin
                        m_beats[m_k] = mem_if.rdata;
                        perr_nx = (mem_if.rlast != (m_k == BEATS - 1));
                        m_k++;
                        if (m_k == BEATS) m_ph = PH_WRITE;
                    end
                end else begin
                    m_count++;
                    m_ph = PH_IDLE;
                end
                if (fence && old_ph != PH_IDLE) m_pend = 1'b1;
                if (old_ph == PH_WRITE) begin inv_nx = m_pend; m_pend = 1'b0; end
                m_inv = inv_nx;
                m_perr = perr_nx;
            end
        end
    end

    // ---------------- directed + random driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic wait_we(output int n, output logic [511:0] line);
        n = 0;
        while (cache_we !== 1'b1 && n < 300) begin tick(); settle(); n++; end
        chk_b("write_seen", cache_we, 1'b1);
        line = cache_line;
    endtask

    task automatic run_miss(input logic [63:0] a, output logic stall0, output int ar_first,
                            output logic [63:0] ar_addr, output int we_cyc, output logic [511:0] line);
        int n, m;
        tick();
        fetch_req = 1'b1; instr_addr = a; hit = 1'b0; ma = 1'b0;
        settle();
        stall0 = stall;
        n = 0;
        while (mem_if.arvalid !== 1'b1 && n < 300) begin tick(); settle(); n++; end
        ar_first = n;
        ar_addr = mem_if.araddr;
        wait_we(m, line);
        we_cyc = n + m;
        tick();
        hit = 1'b1;
        settle();
    endtask

    task automatic go_idle(input int n);
        fetch_req = 1'b0; hit = 1'b0; ma = 1'b0; fence = 1'b0;
        repeat (n) tick();
        settle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic         s0;
        int           af, wc, n, s_we, s_ar, s_perr;
        logic [63:0]  aa;
        logic [511:0] ln;
        arst = 1'b1; fetch_req = 1'b0; hit = 1'b0; ma = 1'b0; fence = 1'b0; instr_addr = '0;
        repeat (3) tick();
        arst = 1'b0;
        settle();
        chk_b("reset_stall", stall, 1'b0);
        chk_b("reset_arvalid", mem_if.arvalid, 1'b0);
        chk_b("reset_rready", mem_if.rready, 1'b0);
        chk_b("reset_we", cache_we, 1'b0);
        chk_b("reset_inv", inv, 1'b0);
        chk_b("reset_perr", perr, 1'b0);
        chk_w("reset_miss_count", 64'(miss_count), 64'd0);

        // zero-wait refill latency and line layout
        run_miss(64'h8000_0044, s0, af, aa, wc, ln);
        chk_b("miss_stall_c0", s0, 1'b1);
        chk_i("first_arvalid_cycle", af, 1);
        chk_w("araddr_line", aa, 64'h8000_0040);
        chk_i("write_cycle", wc, 10);
        chk_w("beat0", ln[63:0], 64'h1111_1111_1111_1111);
        chk_w("beat7", ln[511:448], 64'h8888_8888_8888_8888);
        chk_b("hit_after_fill_stall", stall, 1'b0);
        chk_w("miss_count_1", 64'(miss_count), 64'd1);
        go_idle(2);

        // slow arready, gapped read data
        ar_delay = 5; gap = 1'b1;
        s_we = obs_we; s_ar = obs_ar;
        run_miss(64'h8000_1238, s0, af, aa, wc, ln);
        chk_w("slow_araddr", aa, 64'h8000_1200);
        chk_w("slow_beat1", ln[127:64], 64'h2222_2222_2222_2222);
        chk_w("slow_beat7", ln[511:448], 64'h8888_8888_8888_8888);
        go_idle(3);
        chk_i("slow_we_pulses", obs_we - s_we, 1);
        chk_i("slow_arvalid_cycles", obs_ar - s_ar, 6);
        ar_delay = 0; gap = 1'b0;

        // early rlast on beat 5 (rlast also on beat 8)
        rlast_mask = 8'b1001_0000;
        s_perr = obs_perr; s_we = obs_we;
        run_miss(64'h8000_3080, s0, af, aa, wc, ln);
        chk_i("early_rlast_write_cycle", wc, 10);
        chk_w("early_rlast_beat4", ln[319:256], 64'h5555_5555_5555_5555);
        go_idle(3);
        chk_i("early_rlast_perr_pulses", obs_perr - s_perr, 1);
        chk_i("early_rlast_we_pulses", obs_we - s_we, 1);
        rlast_mask = 8'h80;

        // fence.i during fill
        tick();
        fetch_req = 1'b1; instr_addr = 64'h8000_4000; hit = 1'b0;
        settle();
        n = 0;
        while (mem_if.rready !== 1'b1 && n < 50) begin tick(); settle(); n++; end
        tick(); fence = 1'b1; settle();
        tick(); fence = 1'b0; settle();
        wait_we(n, ln);
        chk_b("fence_fill_inv_at_write", inv, 1'b0);
        tick(); hit = 1'b1; settle();
        chk_b("fence_fill_inv_after_write", inv, 1'b1);
        tick(); settle();
        chk_b("fence_fill_inv_one_cycle", inv, 1'b0);
        go_idle(2);

        // fence.i in idle together with a miss
        tick();
        fence = 1'b1; fetch_req = 1'b1; instr_addr = 64'h8000_2010; hit = 1'b0;
        settle();
        chk_b("fence_idle_c0_arvalid", mem_if.arvalid, 1'b0);
        tick(); fence = 1'b0; settle();
        chk_b("fence_idle_c1_inv", inv, 1'b1);
        chk_b("fence_idle_c1_arvalid", mem_if.arvalid, 1'b0);
        tick(); settle();
        chk_b("fence_idle_c2_arvalid", mem_if.arvalid, 1'b1);
        wait_we(n, ln);
        tick(); hit = 1'b1; settle();
        go_idle(2);

        // reset in the middle of the fill
        s_we = obs_we;
        tick();
        fetch_req = 1'b1; instr_addr = 64'h8000_5000; hit = 1'b0;
        settle();
        n = 0;
        while (!(mem_if.rready === 1'b1 && rb == 3) && n < 100) begin tick(); settle(); n++; end
        chk_i("reset_beat_reached", rb, 3);
        arst = 1'b1;
        tick();
        arst = 1'b0; fetch_req = 1'b0;
        settle();
        chk_b("midfill_reset_rready", mem_if.rready, 1'b0);
        chk_b("midfill_reset_arvalid", mem_if.arvalid, 1'b0);
        chk_b("midfill_reset_we", cache_we, 1'b0);
        chk_w("midfill_reset_miss_count", 64'(miss_count), 64'd0);
        repeat (12) begin tick(); settle(); end
        chk_i("midfill_reset_no_write", obs_we - s_we, 0);

        // misaligned fetch never refills
        tick();
        fetch_req = 1'b1; instr_addr = 64'h8000_0042; ma = 1'b1; hit = 1'b0;
        settle();
        repeat (5) begin
            chk_b("misaligned_stall", stall, 1'b0);
            chk_b("misaligned_arvalid", mem_if.arvalid, 1'b0);
            tick(); settle();
        end
        go_idle(2);

        // random traffic against the model
        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            fetch_req  = ($urandom_range(0, 3) != 0);
            hit        = ($urandom_range(0, 1) != 0);
            ma         = ($urandom_range(0, 7) == 0);
            instr_addr = {$urandom, $urandom};
            fence      = ($urandom_range(0, 24) == 0);
            arst       = ($urandom_range(0, 499) == 0);
        end
        tick();
        rand_mode = 1'b0; arst = 1'b0;
        go_idle(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
